// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider with per-channel shadow config.
// Each channel makes a D-cycle waveform with H high cycles and a rise tick.
module multi_clock_divider #(
  parameter int NUM_CHANNELS = 4,
  parameter int DIV_WIDTH    = 16,
  parameter int DEFAULT_DIV  = 2,
  parameter int CH_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk_FPGA,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] enable,
  input  logic                    cfg_valid,
  input  logic [CH_WIDTH-1:0]     cfg_channel,
  input  logic [DIV_WIDTH-1:0]    cfg_divisor,
  input  logic [DIV_WIDTH-1:0]    cfg_high,
  output logic                    cfg_ready,
  output logic                    cfg_error,
  output logic [NUM_CHANNELS-1:0] cfg_pending,
  output logic [NUM_CHANNELS-1:0] clock_signal,
  output logic [NUM_CHANNELS-1:0] tick
);

  localparam logic [DIV_WIDTH-1:0] ONE   = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] TWO   = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] RST_D = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] RST_H = DIV_WIDTH'(DEFAULT_DIV / 2);

  logic [NUM_CHANNELS-1:0] sel;
  logic [NUM_CHANNELS-1:0] write;
  logic                    in_range;
  logic                    params_ok;
  logic                    accept;
  logic                    req_ok;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      sel[i] = (cfg_channel == CH_WIDTH'(i));
    end
  end

  // Out-of-range channels never have a pending update, so they are
  // always accepted and then flagged as errors.
  assign in_range  = |sel;
  assign cfg_ready = ~|(sel & cfg_pending);
  assign params_ok = (cfg_divisor >= TWO) && (cfg_high != '0) &&
                     (cfg_high < cfg_divisor);
  assign accept    = cfg_valid && cfg_ready;
  assign req_ok    = in_range && params_ok;
  assign write     = sel & {NUM_CHANNELS{accept && req_ok}};

  always_ff @(posedge clk_FPGA or posedge reset) begin
    if (reset) begin
      cfg_error <= 1'b0;
    end else begin
      cfg_error <= accept && !req_ok;
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] high_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] sdiv_q;
    logic [DIV_WIDTH-1:0] shigh_q;
    logic                 pend_q;
    logic                 out_q;
    logic                 tick_q;
    logic                 wrap;
    logic [DIV_WIDTH:0]   nxt;

    assign wrap = (cnt_q == div_q - ONE);
    assign nxt  = {1'b0, cnt_q} + {1'b0, ONE};

    always_ff @(posedge clk_FPGA or posedge reset) begin
      if (reset) begin
        div_q   <= RST_D;
        high_q  <= RST_H;
        cnt_q   <= RST_D - ONE;
        sdiv_q  <= RST_D;
        shigh_q <= RST_H;
        pend_q  <= 1'b0;
        out_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        if (!enable[g]) begin
          out_q  <= 1'b0;
          tick_q <= 1'b0;
          if (pend_q) begin
            div_q  <= sdiv_q;
            high_q <= shigh_q;
            cnt_q  <= sdiv_q - ONE;
            pend_q <= 1'b0;
          end else begin
            cnt_q <= div_q - ONE;
          end
        end else if (wrap) begin
          cnt_q  <= '0;
          out_q  <= 1'b1;
          tick_q <= 1'b1;
          if (pend_q) begin
            div_q  <= sdiv_q;
            high_q <= shigh_q;
            pend_q <= 1'b0;
          end
        end else begin
          cnt_q  <= nxt[DIV_WIDTH-1:0];
          out_q  <= (nxt < {1'b0, high_q});
          tick_q <= 1'b0;
        end
        // Accepts only happen with pend_q low, so no clash with the apply.
        if (write[g]) begin
          sdiv_q  <= cfg_divisor;
          shigh_q <= cfg_high;
          pend_q  <= 1'b1;
        end
      end
    end

    assign cfg_pending[g]  = pend_q;
    assign clock_signal[g] = out_q;
    assign tick[g]         = tick_q;
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Scoreboard bench for multi_clock_divider.
// A period-pattern reference model predicts every registered output.
module tb_multi_clock_divider;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 3;
  localparam int DD = 2;

  logic          clk_FPGA = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  enable = '0;
  logic          cfg_valid = 1'b0;
  logic [CW-1:0] cfg_channel = '0;
  logic [W-1:0]  cfg_divisor = '0;
  logic [W-1:0]  cfg_high = '0;
  logic          cfg_ready;
  logic          cfg_error;
  logic [N-1:0]  cfg_pending;
  logic [N-1:0]  clock_signal;
  logic [N-1:0]  tick;

  multi_clock_divider #(
    .NUM_CHANNELS(N),
    .DIV_WIDTH(W),
    .DEFAULT_DIV(DD),
    .CH_WIDTH(CW)
  ) dut (
    .clk_FPGA(clk_FPGA),
    .reset(reset),
    .enable(enable),
    .cfg_valid(cfg_valid),
    .cfg_channel(cfg_channel),
    .cfg_divisor(cfg_divisor),
    .cfg_high(cfg_high),
    .cfg_ready(cfg_ready),
    .cfg_error(cfg_error),
    .cfg_pending(cfg_pending),
    .clock_signal(clock_signal),
    .tick(tick)
  );

  always #5 clk_FPGA = ~clk_FPGA;

  typedef struct {
    logic [N-1:0] clk;
    logic [N-1:0] tk;
    logic [N-1:0] pend;
    logic         err;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  // Reference: active D/H, shadow, pending flag, and the remaining
  // samples of the period currently being played out.
  int md[N];
  int mh[N];
  int sd[N];
  int sh[N];
  bit mpend[N];
  bit pat[N][$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      md[i] = DD;
      mh[i] = DD / 2;
      sd[i] = DD;
      sh[i] = DD / 2;
      mpend[i] = 1'b0;
      pat[i].delete();
    end
  endfunction

  function automatic bit model_ready(int ch);
    return (ch >= N) || !mpend[ch];
  endfunction

  function automatic exp_t model_step(logic [N-1:0] en, bit v,
                                      int ch, int d, int h);
    exp_t e;
    bit   acc;
    bit   ok;
    e.clk  = '0;
    e.tk   = '0;
    e.pend = '0;
    acc = v && model_ready(ch);
    ok  = (ch < N) && (d >= 2) && (h >= 1) && (h < d);
    e.err = acc && !ok;
    for (int i = 0; i < N; i++) begin
      if (en[i]) begin
        if (pat[i].size() == 0) begin
          if (mpend[i]) begin
            md[i] = sd[i];
            mh[i] = sh[i];
            mpend[i] = 1'b0;
          end
          for (int k = 0; k < md[i]; k++) pat[i].push_back(k < mh[i]);
          e.tk[i] = 1'b1;
        end
        e.clk[i] = pat[i].pop_front();
      end else begin
        pat[i].delete();
        if (mpend[i]) begin
          md[i] = sd[i];
          mh[i] = sh[i];
          mpend[i] = 1'b0;
        end
      end
    end
    if (acc && ok) begin
      sd[ch] = d;
      sh[ch] = h;
      mpend[ch] = 1'b1;
    end
    for (int i = 0; i < N; i++) e.pend[i] = mpend[i];
    return e;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.clk  = '0;
    e.tk   = '0;
    e.pend = '0;
    e.err  = 1'b0;
    return e;
  endfunction

  task automatic step(logic [N-1:0] en, bit v, int ch, int d, int h);
    @(negedge clk_FPGA);
    reset       = 1'b0;
    enable      = en;
    cfg_valid   = v;
    cfg_channel = CW'(ch);
    cfg_divisor = W'(d);
    cfg_high    = W'(h);
    #1;
    check("cfg_ready", {31'd0, cfg_ready}, {31'd0, model_ready(ch)});
    last = model_step(en, v, ch, d, h);
    sb.push_back(last);
  endtask

  task automatic idle(logic [N-1:0] en, int n);
    repeat (n) step(en, 1'b0, 0, 0, 0);
  endtask

  task automatic hold_reset(int n);
    repeat (n) begin
      @(negedge clk_FPGA);
      reset     = 1'b1;
      enable    = '0;
      cfg_valid = 1'b0;
      model_reset();
      last = zero_exp();
      sb.push_back(last);
    end
  endtask

  task automatic async_reset();
    @(negedge clk_FPGA);
    #2;
    reset     = 1'b1;
    enable    = '0;
    cfg_valid = 1'b0;
    #1;
    check("rst_clock", {28'd0, clock_signal}, 32'd0);
    check("rst_tick", {28'd0, tick}, 32'd0);
    check("rst_pending", {28'd0, cfg_pending}, 32'd0);
    check("rst_error", {31'd0, cfg_error}, 32'd0);
    model_reset();
    last = zero_exp();
    sb.push_back(last);
    hold_reset(1);
  endtask

  always @(posedge clk_FPGA) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("clock_signal", {28'd0, clock_signal}, {28'd0, mon_e.clk});
      check("tick", {28'd0, tick}, {28'd0, mon_e.tk});
      check("cfg_pending", {28'd0, cfg_pending}, {28'd0, mon_e.pend});
      check("cfg_error", {31'd0, cfg_error}, {31'd0, mon_e.err});
    end
  end

  initial begin
    logic [N-1:0] en;
    int           d;
    model_reset();
    hold_reset(2);

    idle(4'b0001, 8);

    step(4'b0001, 1'b1, 1, 5, 2);
    idle(4'b0001, 2);
    idle(4'b0011, 12);

    step(4'b0011, 1'b1, 2, 4, 2);
    idle(4'b0111, 5);
    step(4'b0111, 1'b1, 2, 6, 3);
    step(4'b0111, 1'b1, 2, 9, 4);
    step(4'b0111, 1'b1, 3, 7, 3);
    idle(4'b0111, 15);

    step(4'b0111, 1'b1, 0, 1, 0);
    idle(4'b0111, 1);
    step(4'b0111, 1'b1, 0, 6, 0);
    idle(4'b0111, 1);
    step(4'b0111, 1'b1, 1, 6, 6);
    idle(4'b0111, 1);
    step(4'b0111, 1'b1, 4, 6, 3);
    idle(4'b0111, 4);

    idle(4'b1111, 3);
    step(4'b1111, 1'b1, 3, 8, 4);
    for (int i = 0; i < 20; i++) begin
      if (last.clk != '0 && last.pend != '0) break;
      idle(4'b1111, 1);
    end
    async_reset();
    idle(4'b0001, 6);

    en = 4'b1111;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 31) == 0) en[b] = ~en[b];
      end
      d = $urandom_range(0, 12);
      step(en, ($urandom_range(0, 2) == 0), $urandom_range(0, 5),
           d, $urandom_range(0, d + 1));
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    @(posedge clk_FPGA);
    @(posedge clk_FPGA);
    #2;
    check("sb_drain", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
